pipe_stage_chain: RTL and testbench

Parametrised chain of elastic pipeline registers with valid/ready handshake, global stall, per-stage flush and an optional skid buffer per stage. It replaces the fixed, handshake-less stage registers between the IF/ID/EX/MEM/WB stages of the pipelined CPU. A flat WIDTH-bit payload enters at stage 0 and leaves at stage DEPTH-1, in order, with no loss or duplication.

---
 rtl/pipe_stage_chain.sv | 152 +++++++++++++++
 tb/tb_pipe_stage_chain.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain
//   Chain of DEPTH elastic pipeline stages with a valid/ready handshake.
//   A WIDTH-bit payload enters at stage 0 and leaves at stage DEPTH-1 in order.
//   Each stage has a main register. With SKID=1 it also has a skid register,
//   so the stage's ready is a registered value. With SKID=0 ready is computed
//   combinationally from downstream.
//
// Ports
//   clk_i        clock, rising edge
//   rst_i        asynchronous reset, active low; clears all valid bits
//   in_valid_i   upstream beat present
//   in_ready_o   chain accepts a beat this cycle
//   in_data_i    upstream payload
//   out_valid_o  beat present at stage DEPTH-1 (masked while stalled)
//   out_ready_i  downstream accepts
//   out_data_o   payload of the oldest entry in stage DEPTH-1
//   stall_i      global freeze: nothing moves, both handshakes are blocked
//   flush_i      per-stage kill mask; bit k empties stage k and drops its input
//   occupancy_o  registered count of valid entries in the chain
module pipe_stage_chain #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 3,
    parameter  int SKID  = 1,
    localparam int CW    = $clog2(2*DEPTH+1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o,
    input  logic             stall_i,
    input  logic [DEPTH-1:0] flush_i,
    output logic [CW-1:0]    occupancy_o
);

    logic [DEPTH-1:0] r_m_valid;
    logic [DEPTH-1:0] r_s_valid;
    logic [WIDTH-1:0] r_m_data [DEPTH];
    logic [WIDTH-1:0] r_s_data [DEPTH];
    logic [CW-1:0]    r_occ;

    logic [DEPTH-1:0] w_m_valid_next;
    logic [DEPTH-1:0] w_s_valid_next;
    logic [WIDTH-1:0] w_m_data_next [DEPTH];
    logic [WIDTH-1:0] w_s_data_next [DEPTH];
    logic [CW-1:0]    w_occ_next;

    // Index k is the beat offered to stage k; index DEPTH is the chain output.
    logic [DEPTH:0]   w_src_valid;
    logic [WIDTH-1:0] w_src_data [DEPTH+1];
    // Index k: stage k accepts this cycle; index DEPTH: downstream accepts.
    logic [DEPTH:0]   w_up_rdy;

    assign w_src_valid[0] = in_valid_i;
    assign w_src_data[0]  = in_data_i;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_src
            assign w_src_valid[gi+1] = r_m_valid[gi];
            assign w_src_data[gi+1]  = r_m_data[gi];
        end
    endgenerate

    // Ready is built from the output back towards the input so that, without
    // a skid register, a stage sees whether its successor frees up this cycle.
    always_comb begin : p_ready
        logic [DEPTH:0] rdy;
        rdy        = '0;
        rdy[DEPTH] = out_ready_i && !stall_i;
        for (int k = DEPTH-1; k >= 0; k--) begin
            if (SKID != 0) begin
                rdy[k] = !stall_i && !r_s_valid[k];
            end else begin
                rdy[k] = !stall_i && (!r_m_valid[k] || rdy[k+1]);
            end
        end
        w_up_rdy = rdy;
    end

    always_comb begin : p_next
        logic fire_in;
        logic leave;
        w_m_valid_next = r_m_valid;
        w_s_valid_next = r_s_valid;
        w_m_data_next  = r_m_data;
        w_s_data_next  = r_s_data;
        w_occ_next     = '0;
        fire_in        = 1'b0;
        leave          = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            fire_in = w_src_valid[k] && w_up_rdy[k];
            leave   = r_m_valid[k] && w_up_rdy[k+1];
            if (leave) begin
                if (r_s_valid[k]) begin
                    // Skid entry is older than anything arriving: it goes to main.
                    w_m_valid_next[k] = 1'b1;
                    w_m_data_next[k]  = r_s_data[k];
                    w_s_valid_next[k] = 1'b0;
                end else begin
                    w_m_valid_next[k] = fire_in;
                    w_m_data_next[k]  = w_src_data[k];
                end
            end else if (fire_in) begin
                if (SKID != 0 && r_m_valid[k]) begin
                    w_s_valid_next[k] = 1'b1;
                    w_s_data_next[k]  = w_src_data[k];
                end else begin
                    w_m_valid_next[k] = 1'b1;
                    w_m_data_next[k]  = w_src_data[k];
                end
            end
            // Flush wins over everything, stall included. The entry that left
            // this stage has already been handed to stage k+1 above.
            if (flush_i[k]) begin
                w_m_valid_next[k] = 1'b0;
                w_s_valid_next[k] = 1'b0;
            end
            w_occ_next = w_occ_next + CW'(w_m_valid_next[k]) + CW'(w_s_valid_next[k]);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_m_valid <= '0;
            r_s_valid <= '0;
            r_occ     <= '0;
        end else begin
            r_m_valid <= w_m_valid_next;
            r_s_valid <= (SKID != 0) ? w_s_valid_next : '0;
            r_occ     <= w_occ_next;
        end
    end

    // Payload registers carry no reset; only the valid bits are meaningful.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_data
            always_ff @(posedge clk_i) begin
                r_m_data[gi] <= w_m_data_next[gi];
                r_s_data[gi] <= w_s_data_next[gi];
            end
        end
    endgenerate

    assign in_ready_o  = w_up_rdy[0];
    assign out_valid_o = w_src_valid[DEPTH] && !stall_i;
    assign out_data_o  = w_src_data[DEPTH];
    assign occupancy_o = r_occ;

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed bench for pipe_stage_chain. Two instances share out_ready/stall/
// flush: dut_a uses SKID=1, dut_b uses SKID=0. Each instance has its own
// input sequence counter so that each one sees a gap-free value stream.
module tb_pipe_stage_chain;
    localparam int W  = 32;
    localparam int D  = 3;
    localparam int CW = $clog2(2*D+1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid_a, in_valid_b;
    logic [W-1:0]  in_data_a, in_data_b;
    logic          in_ready_a, in_ready_b;
    logic          out_valid_a, out_valid_b;
    logic [W-1:0]  out_data_a, out_data_b;
    logic          out_ready;
    logic          stall;
    logic [D-1:0]  flush;
    logic [CW-1:0] occ_a, occ_b;

    always #5 clk = ~clk;

    pipe_stage_chain #(.WIDTH(W), .DEPTH(D), .SKID(1)) dut_a (
        .clk_i(clk), .rst_i(rst_n),
        .in_valid_i(in_valid_a), .in_ready_o(in_ready_a), .in_data_i(in_data_a),
        .out_valid_o(out_valid_a), .out_ready_i(out_ready), .out_data_o(out_data_a),
        .stall_i(stall), .flush_i(flush), .occupancy_o(occ_a)
    );

    pipe_stage_chain #(.WIDTH(W), .DEPTH(D), .SKID(0)) dut_b (
        .clk_i(clk), .rst_i(rst_n),
        .in_valid_i(in_valid_b), .in_ready_o(in_ready_b), .in_data_i(in_data_b),
        .out_valid_o(out_valid_b), .out_ready_i(out_ready), .out_data_o(out_data_b),
        .stall_i(stall), .flush_i(flush), .occupancy_o(occ_b)
    );

    int n_cmp = 0;
    int n_mis = 0;
    int cyc   = 0;
    int next_a, next_b, last_v;
    logic en;
    logic [W-1:0] rx_a[$];
    logic [W-1:0] rx_b[$];
    int first_in_a, first_in_b, first_out_a, first_out_b;
    int last_out_a, last_out_b, gap_a, gap_b, pk_a, pk_b;
    logic s_rdy_a, s_rdy_b, s_ov_a, s_ov_b;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_rx(input string tag, input logic [W-1:0] q[$], input int exp[$]);
        check_eq({tag, "_len"}, 32'(q.size()), 32'(exp.size()));
        for (int i = 0; i < q.size() && i < exp.size(); i++)
            check_eq($sformatf("%s_%0d", tag, i), q[i], 32'(exp[i]));
    endtask

    task automatic upd();
        in_valid_a = en && (next_a <= last_v);
        in_data_a  = next_a;
        in_valid_b = en && (next_b <= last_v);
        in_data_b  = next_b;
    endtask

    // One clock cycle: sample combinational outputs mid-cycle, record
    // handshakes, then step past the edge.
    task automatic tick();
        #2;
        s_rdy_a = in_ready_a;
        s_rdy_b = in_ready_b;
        s_ov_a  = out_valid_a;
        s_ov_b  = out_valid_b;
        if (rst_n) begin
            if (in_valid_a && in_ready_a) begin
                if (first_in_a < 0) first_in_a = cyc;
                next_a++;
            end
            if (in_valid_b && in_ready_b) begin
                if (first_in_b < 0) first_in_b = cyc;
                next_b++;
            end
            if (out_valid_a && out_ready) begin
                $display("[%0d] A out %0d occ %0d", cyc, out_data_a, occ_a);
                rx_a.push_back(out_data_a);
                if (first_out_a < 0) first_out_a = cyc;
                else if (cyc != last_out_a + 1) gap_a++;
                last_out_a = cyc;
            end
            if (out_valid_b && out_ready) begin
                $display("[%0d] B out %0d occ %0d", cyc, out_data_b, occ_b);
                rx_b.push_back(out_data_b);
                if (first_out_b < 0) first_out_b = cyc;
                else if (cyc != last_out_b + 1) gap_b++;
                last_out_b = cyc;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (int'(occ_a) > pk_a) pk_a = int'(occ_a);
        if (int'(occ_b) > pk_b) pk_b = int'(occ_b);
        upd();
    endtask

    task automatic new_scn(input int first, input int last);
        next_a = first; next_b = first; last_v = last; en = 1'b1;
        rx_a.delete(); rx_b.delete();
        first_in_a = -1; first_in_b = -1; first_out_a = -1; first_out_b = -1;
        last_out_a = -1; last_out_b = -1; gap_a = 0; gap_b = 0; pk_a = 0; pk_b = 0;
        upd();
    endtask

    initial begin
        int cnt_a, cnt_b;
        rst_n = 1'b0; out_ready = 1'b1; stall = 1'b0; flush = '0;
        new_scn(1, 100);

        // Reset held with in_valid asserted
        repeat (3) tick();
        check_eq("rst_occ_a", 32'(occ_a), 0);
        check_eq("rst_occ_b", 32'(occ_b), 0);
        check_eq("rst_ovalid_a", 32'(s_ov_a), 0);
        check_eq("rst_ovalid_b", 32'(s_ov_b), 0);
        check_eq("rst_iready_a", 32'(s_rdy_a), 1);
        check_eq("rst_iready_b", 32'(s_rdy_b), 1);
        en = 1'b0; upd();
        rst_n = 1'b1;
        cnt_a = 0; cnt_b = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (s_ov_a) cnt_a++;
            if (s_ov_b) cnt_b++;
        end
        check_eq("idle_outs_a", 32'(cnt_a), 0);
        check_eq("idle_outs_b", 32'(cnt_b), 0);

        // Streaming 1..10 with downstream always ready
        new_scn(1, 10);
        for (int i = 0; i < 14; i++) begin
            tick();
            if (i >= 2 && i <= 9) begin
                check_eq("stream_occ_a", 32'(occ_a), 3);
                check_eq("stream_occ_b", 32'(occ_b), 3);
            end
        end
        check_eq("stream_lat_a", 32'(first_out_a - first_in_a), 3);
        check_eq("stream_lat_b", 32'(first_out_b - first_in_b), 3);
        check_eq("stream_gaps_a", 32'(gap_a), 0);
        check_eq("stream_gaps_b", 32'(gap_b), 0);
        check_rx("stream_rx_a", rx_a, '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10});
        check_rx("stream_rx_b", rx_b, '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10});
        check_eq("stream_end_occ_a", 32'(occ_a), 0);

        // Backpressure: downstream blocked for the first 8 cycles
        new_scn(11, 20);
        for (int i = 0; i < 30; i++) begin
            out_ready = (i >= 8);
            tick();
            if (i == 5) check_eq("bp_full_occ_a", 32'(occ_a), 6);
            if (i == 6) check_eq("bp_full_rdy_a", 32'(s_rdy_a), 0);
            if (i == 11) check_eq("bp_resume_rdy_a", 32'(s_rdy_a), 1);
            if (i == 3) check_eq("bp_full_rdy_b", 32'(s_rdy_b), 0);
            if (i == 8) begin
                check_eq("bp_passthru_rdy_b", 32'(s_rdy_b), 1);
                check_eq("bp_passthru_occ_b", 32'(occ_b), 3);
            end
        end
        check_eq("bp_peak_a", 32'(pk_a), 6);
        check_eq("bp_peak_b", 32'(pk_b), 3);
        check_rx("bp_rx_a", rx_a, '{11, 12, 13, 14, 15, 16, 17, 18, 19, 20});
        check_rx("bp_rx_b", rx_b, '{11, 12, 13, 14, 15, 16, 17, 18, 19, 20});
        check_eq("bp_end_occ_a", 32'(occ_a), 0);
        check_eq("bp_end_occ_b", 32'(occ_b), 0);

        // Flush stage 1 while the chain is backed up
        new_scn(21, 26);
        for (int i = 0; i < 24; i++) begin
            out_ready = (i >= 7);
            flush     = (i == 6) ? 3'b010 : 3'b000;
            tick();
            if (i == 5) check_eq("fl_pre_occ_a", 32'(occ_a), 6);
            if (i == 6) begin
                check_eq("fl_post_occ_a", 32'(occ_a), 4);
                check_eq("fl_post_occ_b", 32'(occ_b), 2);
            end
        end
        flush = '0;
        check_rx("fl_rx_a", rx_a, '{21, 22, 25, 26});
        check_rx("fl_rx_b", rx_b, '{21, 23, 24, 25, 26});

        // Stall for 4 cycles mid-stream with a stage-0 flush in the second
        new_scn(31, 40);
        out_ready = 1'b1;
        for (int i = 0; i < 22; i++) begin
            stall = (i >= 4 && i <= 7);
            flush = (i == 5) ? 3'b001 : 3'b000;
            tick();
            if (i >= 4 && i <= 7) begin
                check_eq("st_ovalid_a", 32'(s_ov_a), 0);
                check_eq("st_iready_a", 32'(s_rdy_a), 0);
                check_eq("st_ovalid_b", 32'(s_ov_b), 0);
                check_eq("st_iready_b", 32'(s_rdy_b), 0);
            end
            if (i == 5) begin
                check_eq("st_flush_occ_a", 32'(occ_a), 2);
                check_eq("st_flush_occ_b", 32'(occ_b), 2);
            end
        end
        stall = 1'b0; flush = '0;
        check_rx("st_rx_a", rx_a, '{31, 32, 33, 35, 36, 37, 38, 39, 40});
        check_rx("st_rx_b", rx_b, '{31, 32, 33, 35, 36, 37, 38, 39, 40});
        check_eq("st_end_occ_a", 32'(occ_a), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
